regs_dump_reader: RTL

//  Sequential reader for the CPU register file's debug read port. On a start

---
 rtl/regs_dump_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regs_dump_reader.sv
// regs_dump_reader
// Walks the register file debug read port from FIRST_REG to LAST_REG and
// streams {addr, data} beats over a valid/ready interface. It is read-only
// with respect to the register file. All outputs come straight from flops.

module regs_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] dbg_raddr,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] cur_next;
    logic [ADDR_W-1:0] raddr_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              valid_next;
    logic              busy_next;
    logic              done_next;

    // Next-state and next-output logic; every register holds by default and
    // abort overrides whatever the current state decided.
    always_comb begin
        state_next = state;
        cur_next   = cur;
        raddr_next = dbg_raddr;
        addr_next  = out_addr;
        data_next  = out_data;
        valid_next = out_valid;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cur_next   = FIRST_A;
                    raddr_next = FIRST_A;
                    state_next = READ;
                end
            end
            READ: begin
                data_next  = dbg_rdata;
                addr_next  = cur;
                valid_next = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    if (cur < LAST_A) begin
                        cur_next   = cur + 1'b1;
                        raddr_next = cur + 1'b1;
                        state_next = READ;
                    end else begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next = IDLE;
            cur_next   = cur;
            raddr_next = dbg_raddr;
            addr_next  = out_addr;
            data_next  = out_data;
            valid_next = 1'b0;
            done_next  = 1'b0;
        end

        busy_next = (state_next != IDLE);
    end

    // State and registered outputs; reset drops everything to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            dbg_raddr <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cur       <= cur_next;
            dbg_raddr <= raddr_next;
            out_addr  <= addr_next;
            out_data  <= data_next;
            out_valid <= valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule
